// File: rtl/system_unit_arbiter_if.sv
// Bundle between the core execute stages, the arbiter and the shared system unit.
// Signal names are from the arbiter's point of view (i_* into it, o_* out of it).
interface system_unit_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_SIZE = 32
);
    logic [NUM_CORES-1:0]                i_req;
    logic [NUM_CORES-1:0][3:0]           i_op;
    logic [NUM_CORES-1:0]                o_gnt;
    logic [3:0]                          o_sys_op;
    logic [DATA_SIZE-1:0]                i_sys_result;
    logic [NUM_CORES-1:0]                o_valid;
    logic [NUM_CORES-1:0]                o_trap;
    logic [NUM_CORES-1:0][DATA_SIZE-1:0] o_result;

    modport slave (
        input  i_req, i_op, i_sys_result,
        output o_gnt, o_sys_op, o_valid, o_trap, o_result
    );

    modport master (
        output i_req, i_op, i_sys_result,
        input  o_gnt, o_sys_op, o_valid, o_trap, o_result
    );
endinterface

// File: rtl/system_unit_arbiter.sv
// Round-robin arbiter sharing one system execution unit among NUM_CORES threads.
// Grant in T, operation to the unit in T+1, per-core valid/trap/result in T+2.
module system_unit_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    system_unit_arbiter_if.slave bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = IW + 1;

    typedef logic [IW-1:0] idx_t;

    // Op encodings 0..5 are counter reads; SCALL/SBREAK and undefined codes trap.
    localparam logic [3:0] OP_RDCYCLE    = 4'd0;
    localparam logic [3:0] OP_RDINSTRETH = 4'd5;

    idx_t                                rr_ptr_q;
    logic                                s1_vld_q;
    idx_t                                s1_idx_q;
    logic [3:0]                          s1_op_q;
    logic                                s2_vld_q;
    idx_t                                s2_idx_q;
    logic                                s2_trap_q;
    logic [NUM_CORES-1:0][DATA_SIZE-1:0] result_q;

    logic                 found;
    idx_t                 win;
    idx_t                 rr_ptr_d;
    logic [CW-1:0]        cand;
    logic [NUM_CORES-1:0] gnt;
    logic [NUM_CORES-1:0] valid;
    logic [NUM_CORES-1:0] trap;
    logic                 s1_trap;

    // Search starts at rr_ptr and wraps; grants are suppressed while in reset.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        gnt   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NUM_CORES)) begin
                cand = cand - CW'(NUM_CORES);
            end
            if (!found && i_areset_n && bus.i_req[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
    end

    assign rr_ptr_d = (win == idx_t'(NUM_CORES - 1)) ? '0 : win + idx_t'(1);
    assign s1_trap  = (s1_op_q > OP_RDINSTRETH);

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rr_ptr_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_op_q   <= OP_RDCYCLE;
            s2_vld_q  <= 1'b0;
            s2_idx_q  <= '0;
            s2_trap_q <= 1'b0;
            result_q  <= '0;
        end else begin
            s1_vld_q <= found;
            if (found) begin
                rr_ptr_q <= rr_ptr_d;
                s1_idx_q <= win;
                s1_op_q  <= bus.i_op[win];
            end
            s2_vld_q  <= s1_vld_q;
            s2_idx_q  <= s1_idx_q;
            s2_trap_q <= s1_vld_q & s1_trap;
            if (s1_vld_q) begin
                result_q[s1_idx_q] <= s1_trap ? '0 : bus.i_sys_result;
            end
        end
    end

    always_comb begin
        valid = '0;
        trap  = '0;
        if (s2_vld_q) begin
            valid[s2_idx_q] = 1'b1;
            trap[s2_idx_q]  = s2_trap_q;
        end
    end

    assign bus.o_gnt    = gnt;
    assign bus.o_sys_op = s1_vld_q ? s1_op_q : OP_RDCYCLE;
    assign bus.o_valid  = valid;
    assign bus.o_trap   = trap;
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_system_unit_arbiter.sv
// Directed bench for system_unit_arbiter: fairness, wrap, traps, back-to-back, mid-flight reset.
module tb_system_unit_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   gcnt[N];

    system_unit_arbiter_if #(.NUM_CORES(N), .DATA_SIZE(DW)) bus();

    system_unit_arbiter #(.NUM_CORES(N), .DATA_SIZE(DW)) dut (
        .i_aclk     (clk),
        .i_areset_n (areset_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) gcnt[k] = 0;
        bus.i_req        = '0;
        bus.i_op         = '0;
        bus.i_sys_result = '0;

        // reset state, grants forced low while in reset
        #2;
        bus.i_req = 4'hF;
        #1;
        chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
        chk("rst_vld", 32'(bus.o_valid), 32'h0);
        chk("rst_trap", 32'(bus.o_trap), 32'h0);
        chk("rst_sysop", 32'(bus.o_sys_op), 32'h0);
        for (int k = 0; k < N; k++) chk("rst_res", bus.o_result[k], 32'h0);
        @(posedge clk);
        #1;
        areset_n  = 1'b1;
        bus.i_req = '0;
        step();

        // fairness: all cores request continuously, core k issues op k
        for (int k = 0; k < N; k++) bus.i_op[k] = 4'(k);
        for (int c = 0; c < 10; c++) begin
            bus.i_req        = (c < 8) ? 4'hF : 4'h0;
            bus.i_sys_result = 32'h100 + 32'(c);
            #1;
            chk("fair_gnt", 32'(bus.o_gnt), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 1) chk("fair_sysop", 32'(bus.o_sys_op), (c - 1 < 8) ? 32'((c - 1) % 4) : 32'd0);
            if (c >= 2) begin
                chk("fair_vld", 32'(bus.o_valid), 32'd1 << ((c - 2) % 4));
                chk("fair_res", bus.o_result[(c - 2) % 4], 32'h100 + 32'(c - 1));
                chk("fair_trap", 32'(bus.o_trap), 32'h0);
            end
            for (int k = 0; k < N; k++) if (bus.o_gnt[k]) gcnt[k]++;
            step();
        end
        for (int k = 0; k < N; k++) chk("fair_count", 32'(gcnt[k]), 32'd2);

        // wrap: last winner was 3, cores 0 and 3 request
        bus.i_op         = '0;
        bus.i_req        = 4'b1001;
        bus.i_sys_result = 32'h200;
        #1;
        chk("wrap_gnt0", 32'(bus.o_gnt), 32'h1);
        step();
        bus.i_sys_result = 32'h201;
        #1;
        chk("wrap_gnt3", 32'(bus.o_gnt), 32'h8);
        step();
        bus.i_req        = '0;
        bus.i_sys_result = 32'h202;
        #1;
        chk("wrap_idle", 32'(bus.o_gnt), 32'h0);
        chk("wrap_vld0", 32'(bus.o_valid), 32'h1);
        chk("wrap_res0", bus.o_result[0], 32'h201);
        step();
        chk("wrap_vld3", 32'(bus.o_valid), 32'h8);
        chk("wrap_res3", bus.o_result[3], 32'h202);
        step();

        // single request, core 2 RDCYCLE
        bus.i_req   = 4'b0100;
        bus.i_op[2] = 4'd0;
        #1;
        chk("single_gnt", 32'(bus.o_gnt), 32'h4);
        step();
        bus.i_req        = '0;
        bus.i_sys_result = 32'h0000_1234;
        #1;
        chk("single_sysop", 32'(bus.o_sys_op), 32'h0);
        chk("single_vld_early", 32'(bus.o_valid), 32'h0);
        step();
        chk("single_vld", 32'(bus.o_valid), 32'h4);
        chk("single_trap", 32'(bus.o_trap), 32'h0);
        chk("single_res", bus.o_result[2], 32'h1234);
        step();

        // trap: core 1 SBREAK
        bus.i_req   = 4'b0010;
        bus.i_op[1] = 4'd7;
        #1;
        chk("trap_gnt", 32'(bus.o_gnt), 32'h2);
        step();
        bus.i_req        = '0;
        bus.i_sys_result = 32'hDEAD_BEEF;
        #1;
        chk("trap_sysop", 32'(bus.o_sys_op), 32'h7);
        step();
        chk("trap_vld", 32'(bus.o_valid), 32'h2);
        chk("trap_flag", 32'(bus.o_trap), 32'h2);
        chk("trap_res1", bus.o_result[1], 32'h0);
        chk("trap_res0", bus.o_result[0], 32'h201);
        chk("trap_res2", bus.o_result[2], 32'h1234);
        chk("trap_res3", bus.o_result[3], 32'h202);
        step();
        bus.i_op[1] = 4'd0;

        // undefined encoding on core 3 traps as well
        bus.i_req   = 4'b1000;
        bus.i_op[3] = 4'hC;
        #1;
        chk("undef_gnt", 32'(bus.o_gnt), 32'h8);
        step();
        bus.i_req        = '0;
        bus.i_sys_result = 32'h55;
        #1;
        chk("undef_sysop", 32'(bus.o_sys_op), 32'hC);
        step();
        chk("undef_vld", 32'(bus.o_valid), 32'h8);
        chk("undef_trap", 32'(bus.o_trap), 32'h8);
        chk("undef_res3", bus.o_result[3], 32'h0);
        step();
        bus.i_op[3] = 4'd0;

        // back-to-back on core 0: RDTIME then RDTIMEH
        bus.i_req   = 4'b0001;
        bus.i_op[0] = 4'd2;
        #1;
        chk("b2b_gnt_a", 32'(bus.o_gnt), 32'h1);
        step();
        bus.i_op[0]      = 4'd3;
        bus.i_sys_result = 32'h3000;
        #1;
        chk("b2b_gnt_b", 32'(bus.o_gnt), 32'h1);
        chk("b2b_sysop_a", 32'(bus.o_sys_op), 32'h2);
        step();
        bus.i_req        = '0;
        bus.i_sys_result = 32'h3001;
        #1;
        chk("b2b_sysop_b", 32'(bus.o_sys_op), 32'h3);
        chk("b2b_vld_a", 32'(bus.o_valid), 32'h1);
        chk("b2b_trap_a", 32'(bus.o_trap), 32'h0);
        chk("b2b_res_a", bus.o_result[0], 32'h3000);
        step();
        chk("b2b_vld_b", 32'(bus.o_valid), 32'h1);
        chk("b2b_res_b", bus.o_result[0], 32'h3001);
        step();
        chk("b2b_vld_end", 32'(bus.o_valid), 32'h0);

        // reset one cycle after a grant to core 1 (pointer then points at 2)
        bus.i_req        = 4'b0010;
        bus.i_sys_result = 32'h77;
        #1;
        chk("mid_gnt", 32'(bus.o_gnt), 32'h2);
        step();
        areset_n  = 1'b0;
        bus.i_req = '0;
        #1;
        chk("mid_vld_rst", 32'(bus.o_valid), 32'h0);
        chk("mid_sysop_rst", 32'(bus.o_sys_op), 32'h0);
        for (int k = 0; k < N; k++) chk("mid_res", bus.o_result[k], 32'h0);
        step();
        chk("mid_vld_t2", 32'(bus.o_valid), 32'h0);
        areset_n = 1'b1;
        step();
        chk("mid_vld_post1", 32'(bus.o_valid), 32'h0);
        step();
        chk("mid_vld_post2", 32'(bus.o_valid), 32'h0);
        bus.i_req = 4'b1010;
        #1;
        chk("mid_regrant", 32'(bus.o_gnt), 32'h2);
        step();
        bus.i_req = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
